// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: combinational stall/bubble generation, flush/interrupt redirect FSM,
// saturating performance counters and a sticky stall watchdog.
module pipe_ctrl #(
    parameter int unsigned     STAGES     = 5,
    parameter int unsigned     EXC_STAGE  = 3,
    parameter int unsigned     PC_W       = 32,
    parameter int unsigned     INT_W      = 6,
    parameter int unsigned     CNT_W      = 32,
    parameter int unsigned     TIMEOUT    = 1024,
    parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(32'hBFC00380)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              flushreq,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic [INT_W-1:0]  int_in,
    input  logic              int_en,
    input  logic              clr_cnt,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic [STAGES-1:0] flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              int_ack,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              timeout
);

    typedef enum logic {
        StRun,
        StFlush
    } state_e;

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;
    logic                int_ack_q, int_ack_d;
    logic [INT_W-1:0]    sync1_q, sync2_q;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]    wdog_q, wdog_d;
    logic                timeout_q, timeout_d;

    logic [STAGES-1:0]   stall_raw;
    logic [STAGES-1:0]   bubble_raw;
    logic [STAGES-1:0]   flush_mask;
    logic                in_flush;
    logic                int_pend;
    logic                take_int;

    assign in_flush = (state_q == StFlush);
    assign int_pend = |sync2_q;

    // Stage i stalls when any stage at or above i requests a hold; the NOP goes just above the top.
    always_comb begin
        stall_raw  = '0;
        bubble_raw = '0;
        flush_mask = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            stall_raw[i]  = |(stallreq >> i);
            flush_mask[i] = (i <= int'(EXC_STAGE));
        end
        for (int i = 1; i < int'(STAGES); i++) begin
            bubble_raw[i] = stall_raw[i-1] & ~stall_raw[i];
        end
    end

    assign stall          = in_flush ? '0 : stall_raw;
    assign bubble         = in_flush ? '0 : bubble_raw;
    assign flush          = in_flush ? flush_mask : '0;
    assign redirect_valid = in_flush;
    assign redirect_pc    = redirect_pc_q;
    assign int_ack        = int_ack_q;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;
    assign timeout        = timeout_q;

    // Interrupts are only taken from RUN with an idle pipeline; a flush request always wins.
    assign take_int = (state_q == StRun) & ~flushreq & int_pend & int_en & ~|stallreq;

    always_comb begin
        state_d       = StRun;
        redirect_pc_d = redirect_pc_q;
        int_ack_d     = 1'b0;
        if (flushreq) begin
            state_d       = StFlush;
            redirect_pc_d = flush_pc;
        end else if (take_int) begin
            state_d       = StFlush;
            redirect_pc_d = INT_VECTOR;
            int_ack_d     = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!in_flush && stall_raw[0] && stall_cnt_q != CntMax) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            // Counted on entry so the count is visible during the FLUSH cycle itself.
            if (state_d == StFlush && flush_cnt_q != CntMax) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        wdog_d    = '0;
        timeout_d = timeout_q;
        if (stall[0]) begin
            wdog_d = (wdog_q == CntMax) ? wdog_q : wdog_q + 1'b1;
        end
        if (TIMEOUT != 0 && wdog_d == TimeoutVal) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            redirect_pc_q <= '0;
            int_ack_q     <= 1'b0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            wdog_q        <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            int_ack_q     <= int_ack_d;
            sync1_q       <= int_in;
            sync2_q       <= sync1_q;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            wdog_q        <= wdog_d;
            timeout_q     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall decode, flush FSM, interrupt path, counters, watchdog, reset.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stallreq;
    logic        flushreq;
    logic [31:0] flush_pc;
    logic [5:0]  int_in;
    logic        int_en;
    logic        clr_cnt;
    logic [4:0]  stall;
    logic [4:0]  bubble;
    logic [4:0]  flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        int_ack;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(
        .STAGES    (5),
        .EXC_STAGE (3),
        .PC_W      (32),
        .INT_W     (6),
        .CNT_W     (32),
        .TIMEOUT   (8),
        .INT_VECTOR(32'hBFC00380)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq      (stallreq),
        .flushreq      (flushreq),
        .flush_pc      (flush_pc),
        .int_in        (int_in),
        .int_en        (int_en),
        .clr_cnt       (clr_cnt),
        .stall         (stall),
        .bubble        (bubble),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .int_ack       (int_ack),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        stallreq = '0;
        flushreq = 1'b0;
        flush_pc = '0;
        int_in   = '0;
        int_en   = 1'b0;
        clr_cnt  = 1'b0;
        #2;
        check("rst_valid", redirect_valid, 0);
        check("rst_pc", redirect_pc, 0);
        check("rst_ack", int_ack, 0);
        check("rst_scnt", stall_cnt, 0);
        check("rst_fcnt", flush_cnt, 0);
        check("rst_tmo", timeout, 0);
        stallreq = 5'b00100;
        #1;
        check("rst_stall_comb", stall, 5'b00111);
        check("rst_bubble_comb", bubble, 5'b01000);
        stallreq = '0;
        tick();
        tick();
        rst = 1'b1;

        // Stall decode and counting
        tick();
        stallreq = 5'b00100;
        #1;
        check("stall_00100", stall, 5'b00111);
        check("bubble_00100", bubble, 5'b01000);
        tick();
        tick();
        tick();
        check("scnt_3", stall_cnt, 3);
        stallreq = 5'b10000;
        #1;
        check("stall_10000", stall, 5'b11111);
        check("bubble_10000", bubble, 5'b00000);
        stallreq = 5'b00001;
        #1;
        check("stall_00001", stall, 5'b00001);
        check("bubble_00001", bubble, 5'b00010);
        stallreq = 5'b01010;
        #1;
        check("stall_01010", stall, 5'b01111);
        check("bubble_01010", bubble, 5'b10000);
        stallreq = '0;
        #1;
        check("stall_none", stall, 5'b00000);
        check("bubble_none", bubble, 5'b00000);
        tick();
        check("scnt_hold", stall_cnt, 3);

        // Single flush
        flushreq = 1'b1;
        flush_pc = 32'h0000_1000;
        tick();
        flushreq = 1'b0;
        check("fl_mask", flush, 5'b01111);
        check("fl_valid", redirect_valid, 1);
        check("fl_pc", redirect_pc, 32'h1000);
        check("fl_cnt1", flush_cnt, 1);
        stallreq = 5'b11111;
        #1;
        check("fl_stall_masked", stall, 0);
        check("fl_bubble_masked", bubble, 0);
        stallreq = '0;
        tick();
        check("fl_done_valid", redirect_valid, 0);
        check("fl_done_mask", flush, 0);
        check("fl_scnt", stall_cnt, 3);

        // Back-to-back flushes
        flushreq = 1'b1;
        flush_pc = 32'h0000_2000;
        tick();
        check("b2b_a_pc", redirect_pc, 32'h2000);
        check("b2b_a_valid", redirect_valid, 1);
        flush_pc = 32'h0000_3000;
        tick();
        flushreq = 1'b0;
        check("b2b_b_pc", redirect_pc, 32'h3000);
        check("b2b_b_valid", redirect_valid, 1);
        check("b2b_cnt", flush_cnt, 3);
        tick();
        check("b2b_done", redirect_valid, 0);

        // Interrupt latency
        int_en = 1'b1;
        int_in = 6'b000001;
        tick();
        check("int_lat1", int_ack, 0);
        tick();
        check("int_lat2", int_ack, 0);
        tick();
        check("int_ack", int_ack, 1);
        check("int_pc", redirect_pc, 32'hBFC00380);
        check("int_valid", redirect_valid, 1);
        check("int_fcnt", flush_cnt, 4);
        int_in = '0;
        int_en = 1'b0;
        tick();
        check("int_ack_pulse", int_ack, 0);
        check("int_done", redirect_valid, 0);
        tick();
        tick();
        tick();

        // Flush and interrupt on the same edge
        int_en = 1'b1;
        int_in = 6'b000001;
        tick();
        tick();
        flushreq = 1'b1;
        flush_pc = 32'h0000_4000;
        tick();
        flushreq = 1'b0;
        check("prio_pc", redirect_pc, 32'h4000);
        check("prio_noack", int_ack, 0);
        tick();
        check("prio_run", redirect_valid, 0);
        tick();
        check("prio_int_ack", int_ack, 1);
        check("prio_int_pc", redirect_pc, 32'hBFC00380);
        check("prio_fcnt", flush_cnt, 6);
        int_en = 1'b0;
        int_in = '0;
        tick();
        tick();
        tick();

        // Watchdog
        stallreq = 5'b00001;
        for (int i = 0; i < 7; i++) tick();
        check("wd_before", timeout, 0);
        tick();
        check("wd_set", timeout, 1);
        check("wd_scnt", stall_cnt, 11);
        stallreq = '0;
        tick();
        check("wd_sticky", timeout, 1);
        stallreq = 5'b00001;
        clr_cnt  = 1'b1;
        tick();
        clr_cnt  = 1'b0;
        stallreq = '0;
        check("clr_scnt", stall_cnt, 0);
        check("clr_fcnt", flush_cnt, 0);
        check("clr_tmo", timeout, 1);

        // Reset during FLUSH
        flushreq = 1'b1;
        flush_pc = 32'h0000_5000;
        tick();
        flushreq = 1'b0;
        check("rf_valid", redirect_valid, 1);
        check("rf_cnt", flush_cnt, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rf_abort_valid", redirect_valid, 0);
        check("rf_abort_mask", flush, 0);
        check("rf_abort_pc", redirect_pc, 0);
        check("rf_abort_fcnt", flush_cnt, 0);
        check("rf_abort_tmo", timeout, 0);
        #1;
        rst = 1'b1;
        tick();
        check("rf_run", redirect_valid, 0);
        flushreq = 1'b1;
        flush_pc = 32'h0000_6000;
        tick();
        flushreq = 1'b0;
        check("rf_after_pc", redirect_pc, 32'h6000);
        check("rf_after_cnt", flush_cnt, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
